cla_seq_ctrl: RTL and testbench

// - Sequencer that drives one shared 4-bit carry-lookahead slice to compute WIDTH-bit sums.
// - Operands are processed one nibble per cycle, LSB nibble first, with a registered ripple carry between nibbles.
// - Sits between a valid/ready operand producer and a valid/ready result consumer.
// - Trades latency for area versus a full-width CLA.

---
 rtl/cla_pkg.sv | 13 +
 rtl/cla4_slice.sv | 31 +++
 rtl/cla_seq_ctrl.sv | 109 ++++++++++
 tb/tb_cla_seq_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead sequencer:
// FSM state encoding and the slice width.
package cla_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice; carries are computed
// directly from generate/propagate terms rather than rippled bit to bit.
module cla4_slice
    import cla_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic [NIB_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[NIB_W-1:0];
    assign cout = c[NIB_W];

endmodule

// File: rtl/cla_seq_ctrl.sv
// Sequencer that computes a WIDTH-bit sum one nibble per cycle through a single
// shared cla4_slice. Defining CLA_SEQ_SUB_EN adds op_sub for A-B subtraction.
module cla_seq_ctrl
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int NIB = WIDTH / NIB_W;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready is high only in IDLE and out_valid only in DONE, so an operand
    // set is never accepted in the same cycle a result is handed off.
    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q, cout_q;
    logic [CW-1:0]    cnt_q;
    logic [NIB_W-1:0] s_sum;
    logic             s_cout;
    logic [WIDTH-1:0] b_load;
    logic             cin_load;

`ifdef CLA_SEQ_SUB_EN
    // Subtraction is A + ~B + 1; B is inverted once at capture time.
    assign b_load   = op_sub ? ~in_b : in_b;
    assign cin_load = op_sub ? 1'b1 : in_cin;
`else
    assign b_load   = in_b;
    assign cin_load = in_cin;
`endif

    cla4_slice u_slice (
        .a    (a_q[cnt_q*NIB_W +: NIB_W]),
        .b    (b_q[cnt_q*NIB_W +: NIB_W]),
        .cin  (carry_q),
        .sum  (s_sum),
        .cout (s_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)            state_d = RUN;
            RUN:     if (cnt_q == CNT_LAST)   state_d = DONE;
            DONE:    if (out_ready)           state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= b_load;
                        carry_q <= cin_load;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q[cnt_q*NIB_W +: NIB_W] <= s_sum;
                    carry_q <= s_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) cout_q <= s_cout;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed bench for cla_seq_ctrl at WIDTH=16 plus a WIDTH=4 instance for the
// single-nibble case; subtraction vectors run when CLA_SEQ_SUB_EN is defined.
module tb_cla_seq_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             in_valid, in_ready, in_cin, op_sub;
    logic [WIDTH-1:0] in_a, in_b, out_sum;
    logic             out_valid, out_ready, out_cout, busy;

    logic             in4_valid, in4_ready, in4_cin, op4_sub;
    logic [3:0]       in4_a, in4_b, out4_sum;
    logic             out4_valid, out4_ready, out4_cout, busy4;

    cla_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef CLA_SEQ_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    cla_seq_ctrl #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in4_valid),
        .in_ready  (in4_ready),
        .in_a      (in4_a),
        .in_b      (in4_b),
        .in_cin    (in4_cin),
`ifdef CLA_SEQ_SUB_EN
        .op_sub    (op4_sub),
`endif
        .out_valid (out4_valid),
        .out_ready (out4_ready),
        .out_sum   (out4_sum),
        .out_cout  (out4_cout),
        .busy      (busy4)
    );

    // scoreboard
    int vectors     = 0;
    int miscompares = 0;
    logic [WIDTH:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver: one operation, optionally holding out_ready low for 'hold' cycles
    task automatic do_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub, input logic [WIDTH-1:0] es,
                         input logic ec, input int hold);
        in_a = a; in_b = b; in_cin = cin; op_sub = sub; in_valid = 1'b1;
        check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_in_ready_run"}, in_ready, 0);
        repeat (NIB - 1) begin
            @(posedge clk); #1;
            check({tag, "_early_valid"}, out_valid, 0);
        end
        @(posedge clk); #1;
        check({tag, "_out_valid"}, out_valid, 1);
        check({tag, "_sum"}, out_sum, es);
        check({tag, "_cout"}, out_cout, ec);
        if (hold > 0) begin
            in_valid = 1'b1; in_a = 16'h5555; in_b = 16'h5555;
            repeat (hold) begin
                @(posedge clk); #1;
                check({tag, "_hold_valid"}, out_valid, 1);
                check({tag, "_hold_sum"}, out_sum, es);
                check({tag, "_hold_cout"}, out_cout, ec);
                check({tag, "_hold_in_ready"}, in_ready, 0);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_post_valid"}, out_valid, 0);
        check({tag, "_post_in_ready"}, in_ready, 1);
    endtask

    logic [WIDTH-1:0] bb_a [3];
    logic [WIDTH-1:0] bb_b [3];
    int  idx, cyc, last_acc, got;
    logic fire_in, fire_out;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; op_sub = 1'b0;
        in4_valid = 1'b0; out4_ready = 1'b0; in4_a = '0; in4_b = '0; in4_cin = 1'b0; op4_sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_cout", out_cout, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("basic", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 0);
        do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 0);
        do_op("hold", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 5);

        // abort in RUN with cnt=2
        in_a = 16'h1234; in_b = 16'h1111; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_no_result", out_valid, 0);
        do_op("after_abort", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 0);

        // back-to-back with in_valid and out_ready held high
        bb_a[0] = 16'h0101; bb_b[0] = 16'h0202; exp_q.push_back(17'h00303);
        bb_a[1] = 16'h8000; bb_b[1] = 16'h8000; exp_q.push_back(17'h10000);
        bb_a[2] = 16'hABCD; bb_b[2] = 16'h1111; exp_q.push_back(17'h0BCDE);
        idx = 0; cyc = 0; last_acc = -1; got = 0;
        in_a = bb_a[0]; in_b = bb_b[0]; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        while (got < 3 && cyc < 100) begin
            @(negedge clk);
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $error("FAIL b2b_extra: observed unexpected result 0x%0h expected none", out_sum);
                end else begin
                    check("b2b_result", {out_cout, out_sum}, exp_q.pop_front());
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            if (fire_in) begin
                if (last_acc >= 0) check("b2b_gap", cyc - last_acc, NIB + 2);
                last_acc = cyc;
                idx++;
                if (idx < 3) begin in_a = bb_a[idx]; in_b = bb_b[idx]; end
                else in_valid = 1'b0;
            end
        end
        check("b2b_count", got, 3);
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;

`ifdef CLA_SEQ_SUB_EN
        do_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 0);
        do_op("sub_pos", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 0);
`endif

        // single-nibble instance: one RUN cycle
        in4_a = 4'hF; in4_b = 4'h1; in4_cin = 1'b0; in4_valid = 1'b1;
        check("w4_in_ready", in4_ready, 1);
        @(posedge clk); #1;
        in4_valid = 1'b0;
        check("w4_run_valid", out4_valid, 0);
        @(posedge clk); #1;
        check("w4_out_valid", out4_valid, 1);
        check("w4_sum", out4_sum, 4'h0);
        check("w4_cout", out4_cout, 1);
        out4_ready = 1'b1;
        @(posedge clk); #1;
        out4_ready = 1'b0;
        check("w4_post_in_ready", in4_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
